// File: rtl/ex_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ex_pipe_ctrl
// Description : Execute-centred pipeline sequencer for the 5-stage core.
//               Owns the ID/EX, EX/MEM and MEM/WB valid bits. Generates all
//               pipeline-register write-enables and flushes. Detects load-use
//               and RAW hazards, selects EX operand forwarding, squashes the
//               wrong path on redirect, freezes on data-memory stall with a
//               timeout trap, and stops the pipe on HALT.
//               Optional feature macro: EX_FWD_EN (operand forwarding; only
//               load-use hazards stall when defined).
// Revision    : 1.0 - initial release
// ============================================================================
module ex_pipe_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [2:0]       id_rs,
    input  logic [2:0]       id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic             id_halt,
    input  logic [2:0]       ex_rs,
    input  logic [2:0]       ex_rt,
    input  logic             ex_rs_used,
    input  logic             ex_rt_used,
    input  logic [2:0]       ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [2:0]       mem_rd,
    input  logic             mem_regwrite,
    input  logic [2:0]       wb_rd,
    input  logic             wb_regwrite,
    input  logic             wb_halt,
    input  logic             br_redirect,
    input  logic             dmem_stall,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_we,
    output logic             exmem_we,
    output logic             memwb_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             ex_vld,
    output logic             mem_vld,
    output logic             wb_vld,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             halted,
    output logic             err
);

    localparam int c_TMO_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LIMIT = c_TMO_W'(MEM_TIMEOUT);
    localparam logic [c_TMO_W-1:0] c_TMO_ONE   = c_TMO_W'(1);
    localparam logic [CNT_W-1:0]   c_CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]   c_CNT_MAX   = {CNT_W{1'b1}};

    localparam logic [1:0] c_ST_RUN      = 2'd0;
    localparam logic [1:0] c_ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] c_ST_HALTED   = 2'd2;
    localparam logic [1:0] c_ST_ERR      = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic [c_TMO_W-1:0] w_tmo_nxt;
    logic               r_halt_pend;
    logic               w_halt_pend_nxt;
    logic               r_ex_vld;
    logic               r_mem_vld;
    logic               r_wb_vld;
    logic [CNT_W-1:0]   r_stall_cnt;

    logic w_pc_we, w_ifid_we, w_idex_we, w_exmem_we, w_memwb_we;
    logic w_ifid_flush, w_idex_flush;
    logic w_stall_inc;
    logic w_active;
    logic w_redirect;
    logic w_halt_id;
    logic w_fetch_stop;
    logic w_id_reads_ex;
    logic w_hazard;

    assign w_redirect    = br_redirect & r_ex_vld;
    assign w_halt_id     = id_halt & id_valid;
    assign w_fetch_stop  = w_halt_id | r_halt_pend;
    assign w_id_reads_ex = id_valid & ((id_rs_used & (id_rs == ex_rd)) |
                                       (id_rt_used & (id_rt == ex_rd)));

`ifdef EX_FWD_EN
    // Forwarding covers ALU results, so only a load in EX must stall.
    assign w_hazard = r_ex_vld & ex_memread & ex_regwrite & w_id_reads_ex;

    // Operand source select; the younger EX/MEM result wins over MEM/WB.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (ex_rs_used & r_mem_vld & mem_regwrite & (mem_rd == ex_rs))
            fwd_a = 2'b01;
        else if (ex_rs_used & r_wb_vld & wb_regwrite & (wb_rd == ex_rs))
            fwd_a = 2'b10;
        if (ex_rt_used & r_mem_vld & mem_regwrite & (mem_rd == ex_rt))
            fwd_b = 2'b01;
        else if (ex_rt_used & r_wb_vld & wb_regwrite & (wb_rd == ex_rt))
            fwd_b = 2'b10;
    end
`else
    logic w_id_reads_mem;
    logic w_unused_nofwd;

    // Without forwarding, any pending write in EX or MEM blocks the reader;
    // WB is covered by regfile write-through.
    assign w_id_reads_mem = id_valid & ((id_rs_used & (id_rs == mem_rd)) |
                                        (id_rt_used & (id_rt == mem_rd)));
    assign w_hazard = (r_ex_vld & ex_regwrite & w_id_reads_ex) |
                      (r_mem_vld & mem_regwrite & w_id_reads_mem);
    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;
    assign w_unused_nofwd = ^{ex_rs, ex_rt, ex_rs_used, ex_rt_used,
                              ex_memread, wb_rd, wb_regwrite};
`endif

    // Next-state and per-cycle enables: freeze > redirect > hazard > advance.
    always_comb begin
        w_state_nxt     = r_state;
        w_tmo_nxt       = r_tmo_cnt;
        w_halt_pend_nxt = r_halt_pend;
        w_pc_we         = 1'b0;
        w_ifid_we       = 1'b0;
        w_idex_we       = 1'b0;
        w_exmem_we      = 1'b0;
        w_memwb_we      = 1'b0;
        w_ifid_flush    = 1'b0;
        w_idex_flush    = 1'b0;
        w_stall_inc     = 1'b0;
        w_active        = (r_state == c_ST_RUN) || (r_state == c_ST_MEM_WAIT);
        if (w_active) begin
            if (dmem_stall) begin
                // The first frozen cycle (from RUN) counts as stall cycle 1.
                w_tmo_nxt   = (r_state == c_ST_RUN) ? c_TMO_ONE : (r_tmo_cnt + c_TMO_ONE);
                w_state_nxt = (w_tmo_nxt >= c_TMO_LIMIT) ? c_ST_ERR : c_ST_MEM_WAIT;
            end else begin
                w_tmo_nxt   = '0;
                w_state_nxt = c_ST_RUN;
                if (w_redirect) begin
                    w_pc_we      = 1'b1;
                    w_ifid_we    = 1'b1;
                    w_idex_we    = 1'b1;
                    w_exmem_we   = 1'b1;
                    w_memwb_we   = 1'b1;
                    w_ifid_flush = 1'b1;
                    w_idex_flush = 1'b1;
                end else if (w_hazard) begin
                    w_idex_we    = 1'b1;
                    w_idex_flush = 1'b1;
                    w_exmem_we   = 1'b1;
                    w_memwb_we   = 1'b1;
                    w_stall_inc  = 1'b1;
                end else begin
                    // After a HALT leaves ID, fetch stays stopped and IF/ID
                    // only ever receives bubbles while older work drains.
                    w_pc_we      = ~w_fetch_stop;
                    w_ifid_we    = 1'b1;
                    w_idex_we    = 1'b1;
                    w_exmem_we   = 1'b1;
                    w_memwb_we   = 1'b1;
                    w_ifid_flush = w_fetch_stop;
                    if (w_halt_id)
                        w_halt_pend_nxt = 1'b1;
                end
            end
            if (r_wb_vld & wb_halt)
                w_state_nxt = c_ST_HALTED;
        end
    end

    // Sequential state: FSM, timeout counter, valid bits, stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_RUN;
            r_tmo_cnt   <= '0;
            r_halt_pend <= 1'b0;
            r_ex_vld    <= 1'b0;
            r_mem_vld   <= 1'b0;
            r_wb_vld    <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_tmo_cnt   <= w_tmo_nxt;
            r_halt_pend <= w_halt_pend_nxt;
            if (w_idex_we)
                r_ex_vld <= id_valid & ~w_idex_flush;
            if (w_exmem_we)
                r_mem_vld <= r_ex_vld;
            if (w_memwb_we)
                r_wb_vld <= r_mem_vld;
            if (w_stall_inc && (r_stall_cnt != c_CNT_MAX))
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
        end
    end

    // Enables are forced low while reset is held.
    assign pc_we      = w_pc_we      & ~rst;
    assign ifid_we    = w_ifid_we    & ~rst;
    assign idex_we    = w_idex_we    & ~rst;
    assign exmem_we   = w_exmem_we   & ~rst;
    assign memwb_we   = w_memwb_we   & ~rst;
    assign ifid_flush = w_ifid_flush & ~rst;
    assign idex_flush = w_idex_flush & ~rst;

    assign ex_vld    = r_ex_vld;
    assign mem_vld   = r_mem_vld;
    assign wb_vld    = r_wb_vld;
    assign stall_cnt = r_stall_cnt;
    assign halted    = (r_state == c_ST_HALTED);
    assign err       = (r_state == c_ST_ERR);

endmodule
`default_nettype wire

// File: tb/tb_ex_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_pipe_ctrl
// Description : Directed self-checking bench for ex_pipe_ctrl (MEM_TIMEOUT=4).
//               Expectations follow the EX_FWD_EN macro setting.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_pipe_ctrl;

`ifdef EX_FWD_EN
    localparam bit c_FWD = 1'b1;
`else
    localparam bit c_FWD = 1'b0;
`endif
    localparam logic [6:0] c_ADV   = 7'b11111_00;
    localparam logic [6:0] c_STALL = 7'b00111_01;
    localparam logic [6:0] c_REDIR = 7'b11111_11;
    localparam logic [6:0] c_NONE  = 7'b00000_00;
    localparam int         c_LU    = c_FWD ? 1 : 2;   // stalls from the load-use step
    localparam int         c_RAW   = c_FWD ? 0 : 2;   // stalls from the ALU RAW step

    logic clk = 1'b0;
    logic rst;
    logic id_valid, id_rs_used, id_rt_used, id_halt;
    logic [2:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic ex_rs_used, ex_rt_used, ex_regwrite, ex_memread;
    logic mem_regwrite, wb_regwrite, wb_halt, br_redirect, dmem_stall;
    logic pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_flush;
    logic ex_vld, mem_vld, wb_vld, halted, err;
    logic [1:0] fwd_a, fwd_b;
    logic [15:0] stall_cnt;
    logic [6:0] we_vec;
    logic [2:0] vld_vec;

    int checks;
    int errors;

    ex_pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_halt(id_halt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rs_used(ex_rs_used), .ex_rt_used(ex_rt_used),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_halt(wb_halt),
        .br_redirect(br_redirect), .dmem_stall(dmem_stall),
        .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we),
        .memwb_we(memwb_we), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .ex_vld(ex_vld), .mem_vld(mem_vld), .wb_vld(wb_vld),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt),
        .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    assign we_vec  = {pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_flush};
    assign vld_vec = {ex_vld, mem_vld, wb_vld};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0; id_halt = 0;
        ex_rs = 0; ex_rt = 0; ex_rs_used = 0; ex_rt_used = 0; ex_rd = 0;
        ex_regwrite = 0; ex_memread = 0; mem_rd = 0; mem_regwrite = 0;
        wb_rd = 0; wb_regwrite = 0; wb_halt = 0; br_redirect = 0; dmem_stall = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        idle();
        id_valid = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", 32'(we_vec), 32'(c_NONE));
        chk("rst_vld", 32'(vld_vec), 0);
        chk("rst_fwd", 32'({fwd_a, fwd_b}), 0);
        chk("rst_cnt", 32'(stall_cnt), 0);
        chk("rst_halt_err", 32'({halted, err}), 0);
        rst = 1'b0;
        id_valid = 0;
        #1;
        chk("idle_adv", 32'(we_vec), 32'(c_ADV));

        // lw r1 enters ID
        id_valid = 1;
        tick();
        chk("lw_in_ex", 32'(ex_vld), 1);
        // lw r1 in EX, add r2,r1,r3 in ID
        ex_rd = 1; ex_memread = 1; ex_regwrite = 1;
        id_rs = 1; id_rs_used = 1; id_rt = 3; id_rt_used = 1;
        #1;
        chk("lu_stall", 32'(we_vec), 32'(c_STALL));
        tick();
        chk("lu_cnt1", 32'(stall_cnt), 1);
        chk("lu_bubble", 32'(ex_vld), 0);
        // lw now in MEM, add still in ID
        ex_memread = 0; ex_regwrite = 0;
        mem_rd = 1; mem_regwrite = 1;
        #1;
        chk("lu_mem_step", 32'(we_vec), 32'(c_FWD ? c_ADV : c_STALL));
        tick();
        chk("lu_cnt_total", 32'(stall_cnt), 32'(c_LU));
        // add in EX (fwd build) with lw result in WB
        idle();
        ex_rs = 1; ex_rs_used = 1; ex_rt = 3; ex_rt_used = 1; ex_rd = 2; ex_regwrite = 1;
        wb_rd = 1; wb_regwrite = 1;
        #1;
        chk("add_ex_vld", 32'(ex_vld), c_FWD ? 1 : 0);
        chk("lw_wb_vld", 32'(wb_vld), 1);
        chk("add_fwd_a", 32'(fwd_a), c_FWD ? 2 : 0);
        chk("add_fwd_b", 32'(fwd_b), 0);
        tick();

        // three independent instructions fill EX, MEM and WB
        idle();
        id_valid = 1;
        repeat (3) tick();
        chk("fill_vld", 32'(vld_vec), 3'b111);
        mem_rd = 5; mem_regwrite = 1; wb_rd = 5; wb_regwrite = 1;
        ex_rs = 5; ex_rs_used = 1; ex_rt = 5; ex_rt_used = 0;
        #1;
        chk("fwd_both_a", 32'(fwd_a), c_FWD ? 1 : 0);
        chk("fwd_unused_b", 32'(fwd_b), 0);
        mem_regwrite = 0; ex_rt_used = 1;
        #1;
        chk("fwd_wb_a", 32'(fwd_a), c_FWD ? 2 : 0);
        chk("fwd_wb_b", 32'(fwd_b), c_FWD ? 2 : 0);
        mem_rd = 0; mem_regwrite = 1; wb_regwrite = 0; ex_rs = 0; ex_rt = 3;
        #1;
        chk("fwd_r0_a", 32'(fwd_a), c_FWD ? 1 : 0);
        chk("fwd_r0_b", 32'(fwd_b), 0);
        tick();

        // taken branch in EX with a load-use condition also present
        idle();
        ex_rd = 7; ex_memread = 1; ex_regwrite = 1;
        id_valid = 1; id_rs = 7; id_rs_used = 1; br_redirect = 1;
        #1;
        chk("redir_we", 32'(we_vec), 32'(c_REDIR));
        tick();
        chk("redir_bubble", 32'(ex_vld), 0);
        chk("redir_cnt", 32'(stall_cnt), 32'(c_LU));

        // add r4 reaches EX
        idle();
        id_valid = 1;
        tick();
        // add r4 in EX, sub reading r4 in ID
        ex_rd = 4; ex_regwrite = 1; ex_rs = 1; ex_rs_used = 1; ex_rt = 2; ex_rt_used = 1;
        id_rs = 4; id_rs_used = 1; id_rt = 4; id_rt_used = 1;
        #1;
        chk("raw_ex_we", 32'(we_vec), 32'(c_FWD ? c_ADV : c_STALL));
        chk("raw_ex_fwd", 32'({fwd_a, fwd_b}), 0);
        tick();
        mem_rd = 4; mem_regwrite = 1;
        #1;
        chk("raw_mem_we", 32'(we_vec), 32'(c_FWD ? c_ADV : c_STALL));
        chk("raw_mem_fwd", 32'({fwd_a, fwd_b}), 0);
        tick();
        chk("raw_cnt", 32'(stall_cnt), 32'(c_LU + c_RAW));
        mem_regwrite = 0; wb_rd = 4; wb_regwrite = 1;
        #1;
        chk("raw_wb_adv", 32'(we_vec), 32'(c_ADV));
        tick();

        // data-memory freeze with a pending redirect
        idle();
        id_valid = 1; dmem_stall = 1; br_redirect = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("freeze_we", 32'(we_vec), 32'(c_NONE));
            tick();
        end
        chk("freeze_hold_ex", 32'(ex_vld), 1);
        chk("freeze_no_err", 32'(err), 0);
        dmem_stall = 0;
        #1;
        chk("release_redir", 32'(we_vec), 32'(c_REDIR));
        tick();
        chk("release_bubble", 32'(ex_vld), 0);

        // memory timeout after four stall cycles
        br_redirect = 0; dmem_stall = 1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("tmo_err", 32'(err), (i >= 4) ? 1 : 0);
            chk("tmo_we", 32'(we_vec), 32'(c_NONE));
            tick();
        end
        dmem_stall = 0;
        #1;
        chk("err_persist", 32'(err), 1);
        chk("err_we", 32'(we_vec), 32'(c_NONE));
        tick();
        chk("err_persist2", 32'(err), 1);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_clears_err", 32'(err), 0);
        chk("rst_we2", 32'(we_vec), 32'(c_NONE));
        rst = 1'b0;

        // HALT in ID
        idle();
        id_valid = 1; id_halt = 1;
        #1;
        chk("halt_pc0", 32'(pc_we), 0);
        tick();
        idle();
        #1;
        chk("halt_pc1", 32'(pc_we), 0);
        tick();
        #1;
        chk("halt_pc2", 32'(pc_we), 0);
        tick();
        chk("halt_in_wb", 32'(wb_vld), 1);
        wb_halt = 1;
        #1;
        chk("halt_not_yet", 32'(halted), 0);
        tick();
        chk("halted_set", 32'(halted), 1);
        idle();
        id_valid = 1;
        #1;
        chk("halted_we", 32'(we_vec), 32'(c_NONE));
        chk("halted_vld", 32'(vld_vec), 0);
        tick();
        chk("halted_stay", 32'(halted), 1);
        chk("halted_vld2", 32'(vld_vec), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_pipe_ctrl.md
Name: ex_pipe_ctrl

Overview:
- Pipeline sequencer for the 5-stage core, centred on the execute stage.
- Owns the valid bits of the ID/EX, EX/MEM and MEM/WB stages and generates every pipeline-register write-enable and flush.
- Detects load-use and RAW hazards, selects execute-stage operand forwarding, and squashes wrong-path instructions on a branch or jump redirect.
- Freezes the pipe on data-memory stall, with a timeout error, and stops the pipe on HALT.

Parameters:
- MEM_TIMEOUT, 16: maximum consecutive dmem_stall cycles tolerated before the error trap.
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  IF/ID holds a fetched instruction.
- id_rs, id_rt  in  3 each  ID source register numbers.
- id_rs_used, id_rt_used  in  1 each  ID instruction reads rs / rt.
- id_halt  in  1  ID instruction is HALT.
- ex_rs, ex_rt  in  3 each  EX source register numbers.
- ex_rs_used, ex_rt_used  in  1 each  EX instruction reads rs / rt.
- ex_rd  in  3  EX destination register.
- ex_regwrite, ex_memread  in  1 each  EX instruction writes a register / is a load.
- mem_rd  in  3  MEM destination register.
- mem_regwrite  in  1  MEM instruction writes a register.
- wb_rd  in  3  WB destination register.
- wb_regwrite, wb_halt  in  1 each  WB instruction writes a register / is HALT.
- br_redirect  in  1  execute resolved a taken branch or jump; PC_Next is the target.
- dmem_stall  in  1  data memory busy.
- pc_we, ifid_we, idex_we, exmem_we, memwb_we  out  1 each  stage register write-enables.
- ifid_flush, idex_flush  out  1 each  load a bubble (valid=0) into that stage.
- ex_vld, mem_vld, wb_vld  out  1 each  stage valid bits.
- fwd_a, fwd_b  out  2 each  EX operand source: 00 = regfile, 01 = EX/MEM result, 10 = MEM/WB result.
- stall_cnt  out  CNT_W  count of load-use and RAW stall cycles; saturates at all-ones.
- halted  out  1  pipe stopped by HALT.
- err  out  1  memory-timeout trap.

Behaviour:
- Reset: asynchronous, active-high, takes effect immediately.
  - All *_we and *_flush outputs = 0.
  - ex_vld = mem_vld = wb_vld = 0.
  - fwd_a = fwd_b = 00; stall_cnt = 0; halted = 0; err = 0.
  - FSM enters RUN; the timeout counter clears.
  - Reset mid-stall or mid-flush discards all state.
- FSM states:
  - RUN.
  - MEM_WAIT.
  - HALTED (absorbing).
  - ERR (absorbing; err = 1).
  - HALTED and ERR exit only via rst. In both, every *_we and *_flush = 0 and valid bits hold.
- Valid bits advance only when their stage write-enable is set:
  - ex_vld <= id_valid & ~idex_flush.
  - mem_vld <= ex_vld.
  - wb_vld <= mem_vld.
- Per-cycle priority in RUN, highest first:
  - Freeze: dmem_stall = 1 → all *_we = 0, no flush, go to MEM_WAIT. A simultaneous br_redirect is not lost: EX is frozen, so it is re-presented on release.
  - Redirect: br_redirect & ex_vld → pc_we = 1 (PC loads PC_Next), all stage we = 1, ifid_flush = 1, idex_flush = 1. This gives 2 bubbles and overrides any stall.
  - Hazard stall → pc_we = 0, ifid_we = 0, idex_we = 1, idex_flush = 1, exmem_we = memwb_we = 1, stall_cnt += 1.
  - Otherwise all we = 1, no flush.
- Load-use hazard: ex_vld & ex_memread & ex_regwrite & ex_rd matches an ID source that is in use (id_rs with id_rs_used, or id_rt with id_rt_used) & id_valid. Exactly 1 stall cycle.
- Forwarding (fwd_a from ex_rs/ex_rs_used, fwd_b from ex_rt/ex_rt_used):
  - Select 01 if mem_vld & mem_regwrite & mem_rd matches.
  - Else select 10 if wb_vld & wb_regwrite & wb_rd matches.
  - Else select 00.
  - EX/MEM wins when both stages match.
- MEM_WAIT:
  - Timeout counter increments each cycle while dmem_stall = 1.
  - dmem_stall = 0 → return to RUN, counter clears; the same cycle is evaluated as RUN.
  - Counter reaches MEM_TIMEOUT with stall still high → ERR, err = 1 on the next edge.
- HALT:
  - id_halt & id_valid & no redirect → pc_we = 0 from that cycle on. Fetch stops while older instructions drain; IF/ID is flushed on the next advance.
  - wb_vld & wb_halt → HALTED on the next edge, halted = 1.
  - A redirect squashing an ID HALT cancels it.
- Register 0 is not special-cased; matches on r0 forward/stall like any other register.

Optional Feature:
- Macro: EX_FWD_EN.
- Defined:
  - Forwarding as above.
  - Only load-use stalls.
- Undefined:
  - fwd_a = fwd_b = 00 always.
  - Any in-use ID source matching a valid, regwrite-set destination in EX or MEM stalls. This covers loads and ALU results alike.
  - WB relies on regfile write-through, so no stall against WB.
  - Worst-case RAW stall = 2 cycles.

Test Plan:
- lw r1 in EX, ID add r2,r1,r3 → 1 cycle with pc_we = 0, ifid_we = 0, idex_flush = 1; stall_cnt 0→1. Next cycle with add in EX: fwd_a = 10.
- Taken beqz in EX (br_redirect = 1, ex_vld = 1) while a load-use condition is also true → pc_we = 1, ifid_flush = idex_flush = 1; next cycle ex_vld = 0; stall_cnt unchanged.
- dmem_stall high 3 cycles with br_redirect high → all we = 0 for 3 cycles, state MEM_WAIT; on the release cycle the flush and pc_we = 1 are issued.
- MEM_TIMEOUT = 4, dmem_stall held 6 cycles → err = 1 after the 4th stall cycle's edge; state ERR persists after stall drops; rst clears err = 0 immediately.
- HALT in ID → pc_we = 0 from that cycle; 3 cycles later wb_halt & wb_vld → halted = 1; no further we.
- EX_FWD_EN undefined: add r4 in EX, ID sub reading r4 → 2 stall cycles (stall_cnt += 2), fwd_a = fwd_b = 00 throughout.
